pipeline_ctrl: RTL and testbench
================================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 The block SHALL have parameter FLUSH_CYCLES, default 2, giving the number of cycles ID/EX are flushed after a trap.
REQ-002 The block SHALL use one clock, clk_i, and an asynchronous active-low reset, rst_ni.
REQ-003 The block SHALL have these ports:
- clk_i  in  1  clock
- rst_ni  in  1  async active-low reset
- id_rs1_i, id_rs2_i  in  5 each  ID source registers
- id_use_rs1_i, id_use_rs2_i  in  1 each  ID instruction reads that source
- ex_rd_i  in  5  EX destination
- ex_we_i  in  1  EX writes rd
- ex_is_ld_i  in  1  EX holds a load
- ex_dat_i  in  32  EX result
- mem_rd_i  in  5  MEM destination
- mem_we_i  in  1  MEM writes rd
- mem_dat_i  in  32  MEM result
- mem_busy_i  in  1  data-memory access not yet acknowledged
- wb_rd_i  in  5  WB destination
- wb_we_i  in  1  WB writes rd
- wb_dat_i  in  32  WB data
- ex_redirect_i  in  1  taken branch/jump resolved in EX
- trap_i  in  1  exception/interrupt taken
- is_fwd_a_o, is_fwd_b_o  out  1 each  ID operand A/B uses forwarded data
- dat_fwd_a_o, dat_fwd_b_o  out  32 each  forwarded data
- stall_if_o, stall_id_o, stall_ex_o  out  1 each  hold the stage register
- bubble_ex_o  out  1  load NOP into EX
- flush_id_o  out  1  invalidate IF/ID
- stall_cnt_o  out  32  stall-cycle counter

Function
REQ-004 Forwarding SHALL be combinational per operand with priority EX > MEM > WB; a source matches a stage when the stage's we=1, rd equals the source, and rd != 0.
REQ-005 A source equal to x0, or with its use bit 0, SHALL give is_fwd=0 and dat_fwd=0.
REQ-006 An EX match with ex_is_ld_i=1 SHALL NOT forward; it is a load-use hazard.
REQ-007 The FSM SHALL have states RUN, MEM_WAIT and TRAP_FLUSH, held in a registered state plus a flush counter.
REQ-008 In RUN, conditions SHALL be evaluated in priority order: trap_i, then mem_busy_i, then ex_redirect_i, then load-use.
REQ-009 RUN with trap_i=1 SHALL assert flush_id_o and bubble_ex_o in the same cycle, go to TRAP_FLUSH, and set the counter to FLUSH_CYCLES-1.
REQ-010 RUN with mem_busy_i=1 SHALL assert stall_if_o, stall_id_o and stall_ex_o in the same cycle and go to MEM_WAIT.
REQ-011 RUN with ex_redirect_i=1 SHALL assert flush_id_o and bubble_ex_o for that cycle only, with no stall even if a load-use hazard exists, and stay in RUN.
REQ-012 RUN with a load-use hazard SHALL assert stall_if_o, stall_id_o and bubble_ex_o for that cycle; the next cycle resolves through MEM forwarding.
REQ-013 MEM_WAIT SHALL assert stall_if_o, stall_id_o and stall_ex_o every cycle while mem_busy_i=1, and SHALL NOT assert flush_id_o or bubble_ex_o.
REQ-014 MEM_WAIT SHALL return to RUN in the cycle after mem_busy_i falls; that cycle's stall outputs are those RUN requires.
REQ-015 trap_i in MEM_WAIT SHALL take precedence and behave as in REQ-009.
REQ-016 A redirect pending during MEM_WAIT is held by the frozen EX stage and SHALL be acted on in RUN.
REQ-017 TRAP_FLUSH SHALL assert flush_id_o and bubble_ex_o with stall_if_o=0; at counter 0 it SHALL return to RUN, otherwise decrement.
REQ-018 trap_i in TRAP_FLUSH SHALL reload the counter to FLUSH_CYCLES-1.
REQ-019 stall_cnt_o SHALL increment by 1 on every clock edge where stall_id_o=1 and saturate at 0xFFFFFFFF.

Reset
REQ-020 Asserting rst_ni=0 SHALL immediately set state=RUN, flush counter=0 and stall_cnt_o=0.
REQ-021 While rst_ni=0, all stall, flush, bubble and is_fwd outputs SHALL be 0.
REQ-022 Reset asserted mid-MEM_WAIT or mid-TRAP_FLUSH SHALL abandon the sequence.
REQ-023 The first edge after release SHALL evaluate from RUN.

Structure
REQ-024 Package pipeline_ctrl_pkg SHALL hold the state enum, the FLUSH_CYCLES default and the REG_X0 constant.
REQ-025 Sub-module fwd_sel (one operand's comparison and priority mux) SHALL be instantiated twice, for A and B.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- id_rs1=5, use=1, ex_rd=5, ex_we=1, ex_dat=0xAAAA, mem_rd=5, mem_dat=0xBBBB -> is_fwd_a_o=1, dat_fwd_a_o=0xAAAA.
- ex_is_ld=1, ex_rd=7, id_rs2=7 -> stall_if/stall_id/bubble_ex=1 one cycle; next cycle, load in MEM (mem_dat=0x1234) -> dat_fwd_b_o=0x1234, no stall.
- id_rs1=0, ex_rd=0, ex_we=1 -> is_fwd_a_o=0, no stall.
- mem_busy_i high 3 cycles -> stall_if/id/ex high 3 cycles, stall_cnt_o +3; trap_i in cycle 2 -> TRAP_FLUSH, flush for 2 cycles.
- ex_redirect_i with a simultaneous load-use hazard -> flush_id_o=1, bubble_ex_o=1, stall_id_o=0.
- stall_cnt forced near 0xFFFFFFFF, 2 more stall cycles -> holds 0xFFFFFFFF; rst_ni low mid-TRAP_FLUSH -> state RUN, outputs 0.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Shared constants and state encoding for the pipeline hazard controller.
package pipeline_ctrl_pkg;

    localparam int          FLUSH_CYCLES_DEF = 2;
    localparam logic [4:0]  REG_X0           = 5'd0;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_MEM_WAIT   = 2'd1,
        ST_TRAP_FLUSH = 2'd2
    } state_e;

    localparam logic [1:0] S_RUN        = ST_RUN;
    localparam logic [1:0] S_MEM_WAIT   = ST_MEM_WAIT;
    localparam logic [1:0] S_TRAP_FLUSH = ST_TRAP_FLUSH;

endpackage

// File: rtl/pipeline_ctrl_fwd_sel.sv
// One ID operand's forwarding selector: EX > MEM > WB priority, x0 never forwarded.
module fwd_sel
    import pipeline_ctrl_pkg::*;
(
    input  logic [4:0]  src_i,
    input  logic        use_i,
    input  logic [4:0]  ex_rd_i,
    input  logic        ex_we_i,
    input  logic        ex_is_ld_i,
    input  logic [31:0] ex_dat_i,
    input  logic [4:0]  mem_rd_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_dat_i,
    input  logic [4:0]  wb_rd_i,
    input  logic        wb_we_i,
    input  logic [31:0] wb_dat_i,
    output logic        is_fwd_o,
    output logic [31:0] dat_o,
    output logic        ld_hit_o
);

    // Priority match; a load in EX claims the operand but has no data yet,
    // so older stages must not supply a stale value in its place.
    always_comb begin
        is_fwd_o = 1'b0;
        dat_o    = 32'd0;
        ld_hit_o = 1'b0;
        if (use_i && (src_i != REG_X0)) begin
            if (ex_we_i && (ex_rd_i == src_i)) begin
                if (ex_is_ld_i) begin
                    ld_hit_o = 1'b1;
                end else begin
                    is_fwd_o = 1'b1;
                    dat_o    = ex_dat_i;
                end
            end else if (mem_we_i && (mem_rd_i == src_i)) begin
                is_fwd_o = 1'b1;
                dat_o    = mem_dat_i;
            end else if (wb_we_i && (wb_rd_i == src_i)) begin
                is_fwd_o = 1'b1;
                dat_o    = wb_dat_i;
            end else begin
                is_fwd_o = 1'b0;
            end
        end else begin
            is_fwd_o = 1'b0;
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use/memory stalls,
// branch redirect flush and multi-cycle trap flush, plus a stall counter.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [4:0]  id_rs1_i,
    input  logic [4:0]  id_rs2_i,
    input  logic        id_use_rs1_i,
    input  logic        id_use_rs2_i,
    input  logic [4:0]  ex_rd_i,
    input  logic        ex_we_i,
    input  logic        ex_is_ld_i,
    input  logic [31:0] ex_dat_i,
    input  logic [4:0]  mem_rd_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_dat_i,
    input  logic        mem_busy_i,
    input  logic [4:0]  wb_rd_i,
    input  logic        wb_we_i,
    input  logic [31:0] wb_dat_i,
    input  logic        ex_redirect_i,
    input  logic        trap_i,
    output logic        is_fwd_a_o,
    output logic        is_fwd_b_o,
    output logic [31:0] dat_fwd_a_o,
    output logic [31:0] dat_fwd_b_o,
    output logic        stall_if_o,
    output logic        stall_id_o,
    output logic        stall_ex_o,
    output logic        bubble_ex_o,
    output logic        flush_id_o,
    output logic [31:0] stall_cnt_o
);

    localparam int              CNT_W      = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      stall_cnt_q, stall_cnt_d;

    logic        fwd_a_s, fwd_b_s, ld_hit_a_s, ld_hit_b_s, load_use_s;
    logic [31:0] dat_a_s, dat_b_s;
    logic        stall_if_s, stall_id_s, stall_ex_s, bubble_s, flush_s;

    fwd_sel u_fwd_a (
        .src_i      (id_rs1_i),
        .use_i      (id_use_rs1_i),
        .ex_rd_i    (ex_rd_i),
        .ex_we_i    (ex_we_i),
        .ex_is_ld_i (ex_is_ld_i),
        .ex_dat_i   (ex_dat_i),
        .mem_rd_i   (mem_rd_i),
        .mem_we_i   (mem_we_i),
        .mem_dat_i  (mem_dat_i),
        .wb_rd_i    (wb_rd_i),
        .wb_we_i    (wb_we_i),
        .wb_dat_i   (wb_dat_i),
        .is_fwd_o   (fwd_a_s),
        .dat_o      (dat_a_s),
        .ld_hit_o   (ld_hit_a_s)
    );

    fwd_sel u_fwd_b (
        .src_i      (id_rs2_i),
        .use_i      (id_use_rs2_i),
        .ex_rd_i    (ex_rd_i),
        .ex_we_i    (ex_we_i),
        .ex_is_ld_i (ex_is_ld_i),
        .ex_dat_i   (ex_dat_i),
        .mem_rd_i   (mem_rd_i),
        .mem_we_i   (mem_we_i),
        .mem_dat_i  (mem_dat_i),
        .wb_rd_i    (wb_rd_i),
        .wb_we_i    (wb_we_i),
        .wb_dat_i   (wb_dat_i),
        .is_fwd_o   (fwd_b_s),
        .dat_o      (dat_b_s),
        .ld_hit_o   (ld_hit_b_s)
    );

    assign load_use_s = ld_hit_a_s | ld_hit_b_s;

    // Control FSM. MEM_WAIT with busy low evaluates exactly like RUN, so the
    // release cycle picks up any redirect or load-use held by the frozen stages.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        stall_if_s = 1'b0;
        stall_id_s = 1'b0;
        stall_ex_s = 1'b0;
        bubble_s   = 1'b0;
        flush_s    = 1'b0;
        case (state_q)
            S_RUN, S_MEM_WAIT: begin
                if (trap_i) begin
                    flush_s  = 1'b1;
                    bubble_s = 1'b1;
                    state_d  = S_TRAP_FLUSH;
                    cnt_d    = CNT_RELOAD;
                end else if (mem_busy_i) begin
                    stall_if_s = 1'b1;
                    stall_id_s = 1'b1;
                    stall_ex_s = 1'b1;
                    state_d    = S_MEM_WAIT;
                end else if (ex_redirect_i) begin
                    flush_s  = 1'b1;
                    bubble_s = 1'b1;
                    state_d  = S_RUN;
                end else if (load_use_s) begin
                    stall_if_s = 1'b1;
                    stall_id_s = 1'b1;
                    bubble_s   = 1'b1;
                    state_d    = S_RUN;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_TRAP_FLUSH: begin
                flush_s  = 1'b1;
                bubble_s = 1'b1;
                if (trap_i) begin
                    cnt_d = CNT_RELOAD;
                end else if (cnt_q == '0) begin
                    state_d = S_RUN;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = S_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are forced quiet while reset is held, regardless of inputs.
    always_comb begin
        is_fwd_a_o  = rst_ni & fwd_a_s;
        is_fwd_b_o  = rst_ni & fwd_b_s;
        dat_fwd_a_o = rst_ni ? dat_a_s : 32'd0;
        dat_fwd_b_o = rst_ni ? dat_b_s : 32'd0;
        stall_if_o  = rst_ni & stall_if_s;
        stall_id_o  = rst_ni & stall_id_s;
        stall_ex_o  = rst_ni & stall_ex_s;
        bubble_ex_o = rst_ni & bubble_s;
        flush_id_o  = rst_ni & flush_s;
    end

    // Saturating stall-cycle counter.
    always_comb begin
        if (stall_id_o && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // State, flush counter and stall counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_RUN;
            cnt_q       <= '0;
            stall_cnt_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed plus random bench for pipeline_ctrl against a behavioural model.
module tb_pipeline_ctrl;

    localparam int FLUSH = 2;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [4:0]  id_rs1_i, id_rs2_i, ex_rd_i, mem_rd_i, wb_rd_i;
    logic        id_use_rs1_i, id_use_rs2_i, ex_we_i, ex_is_ld_i, mem_we_i, wb_we_i;
    logic        mem_busy_i, ex_redirect_i, trap_i;
    logic [31:0] ex_dat_i, mem_dat_i, wb_dat_i;
    logic        is_fwd_a_o, is_fwd_b_o, stall_if_o, stall_id_o, stall_ex_o, bubble_ex_o, flush_id_o;
    logic [31:0] dat_fwd_a_o, dat_fwd_b_o, stall_cnt_o;

    int          n_checks = 0;
    int          n_err = 0;
    int          flush_rem = 0;
    logic [31:0] m_cnt = 32'd0;
    logic [31:0] cnt_snap;

    pipeline_ctrl #(.FLUSH_CYCLES(FLUSH)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
        .id_use_rs1_i(id_use_rs1_i), .id_use_rs2_i(id_use_rs2_i),
        .ex_rd_i(ex_rd_i), .ex_we_i(ex_we_i), .ex_is_ld_i(ex_is_ld_i), .ex_dat_i(ex_dat_i),
        .mem_rd_i(mem_rd_i), .mem_we_i(mem_we_i), .mem_dat_i(mem_dat_i), .mem_busy_i(mem_busy_i),
        .wb_rd_i(wb_rd_i), .wb_we_i(wb_we_i), .wb_dat_i(wb_dat_i),
        .ex_redirect_i(ex_redirect_i), .trap_i(trap_i),
        .is_fwd_a_o(is_fwd_a_o), .is_fwd_b_o(is_fwd_b_o),
        .dat_fwd_a_o(dat_fwd_a_o), .dat_fwd_b_o(dat_fwd_b_o),
        .stall_if_o(stall_if_o), .stall_id_o(stall_id_o), .stall_ex_o(stall_ex_o),
        .bubble_ex_o(bubble_ex_o), .flush_id_o(flush_id_o), .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        id_rs1_i = 5'd0; id_rs2_i = 5'd0; id_use_rs1_i = 1'b0; id_use_rs2_i = 1'b0;
        ex_rd_i = 5'd0; ex_we_i = 1'b0; ex_is_ld_i = 1'b0; ex_dat_i = 32'd0;
        mem_rd_i = 5'd0; mem_we_i = 1'b0; mem_dat_i = 32'd0; mem_busy_i = 1'b0;
        wb_rd_i = 5'd0; wb_we_i = 1'b0; wb_dat_i = 32'd0;
        ex_redirect_i = 1'b0; trap_i = 1'b0;
    endtask

    // Reference forwarding: scan stages youngest first; a load in EX blocks.
    function automatic void fwd_model(input logic [4:0] src, input logic use_b,
                                      output logic f, output logic [31:0] d, output logic lu);
        logic [4:0]  rds [3];
        logic        wes [3];
        logic [31:0] dts [3];
        rds = '{ex_rd_i, mem_rd_i, wb_rd_i};
        wes = '{ex_we_i, mem_we_i, wb_we_i};
        dts = '{ex_dat_i, mem_dat_i, wb_dat_i};
        f = 1'b0; d = 32'd0; lu = 1'b0;
        if (use_b && src != 5'd0) begin
            for (int k = 0; k < 3; k++) begin
                if (wes[k] && rds[k] == src) begin
                    if (k == 0 && ex_is_ld_i) lu = 1'b1;
                    else begin f = 1'b1; d = dts[k]; end
                    break;
                end
            end
        end
    endfunction

    // One clock cycle: compare combinational outputs, clock, compare counter.
    task automatic step(input string tag);
        logic fa, fb, la, lb, e_if, e_id, e_ex, e_bub, e_fl;
        logic [31:0] da, db;
        #1;
        if (!rst_ni) begin flush_rem = 0; m_cnt = 32'd0; end
        fwd_model(id_rs1_i, id_use_rs1_i, fa, da, la);
        fwd_model(id_rs2_i, id_use_rs2_i, fb, db, lb);
        {e_if, e_id, e_ex, e_bub, e_fl} = 5'b00000;
        if (trap_i || flush_rem > 0)   begin e_bub = 1'b1; e_fl = 1'b1; end
        else if (mem_busy_i)           begin e_if = 1'b1; e_id = 1'b1; e_ex = 1'b1; end
        else if (ex_redirect_i)        begin e_bub = 1'b1; e_fl = 1'b1; end
        else if (la || lb)             begin e_if = 1'b1; e_id = 1'b1; e_bub = 1'b1; end
        if (!rst_ni) begin {e_if, e_id, e_ex, e_bub, e_fl, fa, fb} = 7'd0; end
        check({tag, "_fwd_a"}, {31'd0, is_fwd_a_o}, {31'd0, fa});
        check({tag, "_fwd_b"}, {31'd0, is_fwd_b_o}, {31'd0, fb});
        if (rst_ni) begin
            check({tag, "_dat_a"}, dat_fwd_a_o, da);
            check({tag, "_dat_b"}, dat_fwd_b_o, db);
        end
        check({tag, "_ctl"}, {27'd0, stall_if_o, stall_id_o, stall_ex_o, bubble_ex_o, flush_id_o},
              {27'd0, e_if, e_id, e_ex, e_bub, e_fl});
        @(posedge clk_i);
        if (rst_ni) begin
            if (e_id && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
            if (trap_i) flush_rem = FLUSH;
            else if (flush_rem > 0) flush_rem--;
        end
        #1;
        check({tag, "_cnt"}, stall_cnt_o, m_cnt);
        @(negedge clk_i);
    endtask

    initial begin
        rst_ni = 1'b0;
        clear_inputs();
        @(negedge clk_i);
        // reset state, with hazard-looking inputs present
        trap_i = 1'b1; mem_busy_i = 1'b1; id_rs1_i = 5'd3; id_use_rs1_i = 1'b1; ex_rd_i = 5'd3; ex_we_i = 1'b1;
        step("reset");
        check("reset_cnt0", stall_cnt_o, 32'd0);
        clear_inputs();
        rst_ni = 1'b1;
        step("idle");

        // EX beats MEM
        id_rs1_i = 5'd5; id_use_rs1_i = 1'b1; ex_rd_i = 5'd5; ex_we_i = 1'b1; ex_dat_i = 32'hAAAA;
        mem_rd_i = 5'd5; mem_we_i = 1'b1; mem_dat_i = 32'hBBBB;
        #1;
        check("exprio_dat", dat_fwd_a_o, 32'h0000_AAAA);
        check("exprio_is", {31'd0, is_fwd_a_o}, 32'd1);
        step("exprio");

        // load-use stall, then MEM forward
        clear_inputs();
        ex_is_ld_i = 1'b1; ex_we_i = 1'b1; ex_rd_i = 5'd7; id_rs2_i = 5'd7; id_use_rs2_i = 1'b1;
        #1;
        check("lu_stall", {29'd0, stall_if_o, stall_id_o, bubble_ex_o}, 32'd7);
        step("lu1");
        clear_inputs();
        mem_rd_i = 5'd7; mem_we_i = 1'b1; mem_dat_i = 32'h1234; id_rs2_i = 5'd7; id_use_rs2_i = 1'b1;
        #1;
        check("lu_fwd_b", dat_fwd_b_o, 32'h0000_1234);
        check("lu_nostall", {31'd0, stall_id_o}, 32'd0);
        step("lu2");

        // x0 never forwards
        clear_inputs();
        id_use_rs1_i = 1'b1; ex_we_i = 1'b1;
        #1;
        check("x0_fwd", {31'd0, is_fwd_a_o}, 32'd0);
        check("x0_stall", {31'd0, stall_id_o}, 32'd0);
        step("x0");

        // memory busy for 3 cycles
        clear_inputs();
        cnt_snap = m_cnt;
        mem_busy_i = 1'b1;
        for (int i = 0; i < 3; i++) step("busy");
        mem_busy_i = 1'b0;
        check("busy_cnt3", stall_cnt_o, cnt_snap + 32'd3);
        step("busy_rel");

        // busy, then trap in the second busy cycle
        mem_busy_i = 1'b1;
        step("bt1");
        trap_i = 1'b1;
        #1;
        check("bt_trap_fl", {30'd0, flush_id_o, stall_id_o}, 32'd2);
        step("bt2");
        trap_i = 1'b0; mem_busy_i = 1'b0;
        for (int i = 0; i < FLUSH; i++) begin
            #1;
            check("bt_flushing", {30'd0, flush_id_o, stall_if_o}, 32'd2);
            step("btf");
        end
        #1;
        check("bt_done", {31'd0, flush_id_o}, 32'd0);
        step("bt_after");

        // redirect beats load-use
        clear_inputs();
        ex_redirect_i = 1'b1; ex_is_ld_i = 1'b1; ex_we_i = 1'b1; ex_rd_i = 5'd9;
        id_rs1_i = 5'd9; id_use_rs1_i = 1'b1;
        #1;
        check("redir", {29'd0, flush_id_o, bubble_ex_o, stall_id_o}, 32'd6);
        step("redir");
        clear_inputs();

        // saturation
        force dut.stall_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.stall_cnt_q;
        m_cnt = 32'hFFFF_FFFE;
        mem_busy_i = 1'b1;
        step("sat1");
        step("sat2");
        check("sat_hold", stall_cnt_o, 32'hFFFF_FFFF);
        mem_busy_i = 1'b0;
        step("sat_rel");

        // reset in the middle of a trap flush
        trap_i = 1'b1;
        step("rt_trap");
        trap_i = 1'b0;
        step("rt_flush");
        rst_ni = 1'b0;
        #1;
        check("rt_async", {29'd0, flush_id_o, bubble_ex_o, stall_id_o}, 32'd0);
        check("rt_cnt", stall_cnt_o, 32'd0);
        step("rt_inrst");
        rst_ni = 1'b1;
        #1;
        check("rt_run", {31'd0, flush_id_o}, 32'd0);
        step("rt_after");

        // random traffic against the model
        for (int n = 0; n < 400; n++) begin
            id_rs1_i = 5'($urandom_range(0, 3)); id_rs2_i = 5'($urandom_range(0, 3));
            id_use_rs1_i = 1'($urandom); id_use_rs2_i = 1'($urandom);
            ex_rd_i = 5'($urandom_range(0, 3)); ex_we_i = 1'($urandom); ex_is_ld_i = 1'($urandom);
            mem_rd_i = 5'($urandom_range(0, 3)); mem_we_i = 1'($urandom);
            wb_rd_i = 5'($urandom_range(0, 3)); wb_we_i = 1'($urandom);
            ex_dat_i = $urandom; mem_dat_i = $urandom; wb_dat_i = $urandom;
            mem_busy_i = ($urandom_range(0, 3) == 0);
            ex_redirect_i = ($urandom_range(0, 5) == 0);
            trap_i = ($urandom_range(0, 15) == 0);
            rst_ni = ($urandom_range(0, 63) != 0);
            step("rnd");
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
